// File: rtl/mw_pkg.sv
// Shared types and ARM32 field positions for the memory-wait pipeline stage.
package mw_pkg;

    typedef enum logic [1:0] {MW_EMPTY, MW_WAIT, MW_FULL} mw_state_t;

    localparam int         RT_LSB     = 12;
    localparam int         OPC_LSB    = 21;
    localparam int         OPC_W      = 7;
    localparam int         MEMCLS_LSB = 26;
    localparam logic [1:0] MEMCLS_VAL = 2'b01;

    // Takes the two class bits [27:26]; 2'b01 marks single data transfers (LDR/STR).
    function automatic logic is_mem_instr(input logic [1:0] cls);
        return cls == MEMCLS_VAL;
    endfunction

endpackage

// File: rtl/mw_wait_counter.sv
// Saturating wait counter; done flags the last permitted wait cycle of a memory op.
module mw_wait_counter #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = ($clog2(WAIT_CYCLES + 1) > 0) ? $clog2(WAIT_CYCLES + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int               MAX_INT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INT);

    logic [CNT_W-1:0] count_q, count_d;

    // Clear wins over enable; the count parks at MAX_CNT rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != MAX_CNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == MAX_CNT);

endmodule

// File: rtl/memory_wait_stage.sv
// Execute-to-writeback holding stage: registers one instruction and PC, and stalls
// LDR/STR until memory acknowledges or the bounded wait runs out.
module memory_wait_stage
    import mw_pkg::*;
#(
    parameter int INSTR_W     = 32,
    parameter int PC_W        = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               mem_ack,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_output,
    output logic [PC_W-1:0]    pc_out,
    output logic [3:0]         rt,
    output logic [OPC_W-1:0]   opcode,
    output logic               is_mem,
    output logic               busy
);

    localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    mw_state_t          state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               accept;
    logic               cnt_done;

    // Flush and reset both block intake so nothing slips in during those cycles.
    assign in_ready = !rst && !flush &&
                      ((state_q == MW_EMPTY) || ((state_q == MW_FULL) && out_ready));
    assign accept   = in_valid && in_ready;

    mw_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .CNT_W      (CNT_W)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept || flush),
        .en_i  (state_q == MW_WAIT),
        .done_o(cnt_done)
    );

    // An accept overrides the drain-to-EMPTY of a FULL hand-off, giving back-to-back flow.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            state_d = MW_EMPTY;
        end else begin
            case (state_q)
                MW_EMPTY: state_d = MW_EMPTY;
                MW_WAIT:  if (mem_ack || cnt_done) state_d = MW_FULL;
                MW_FULL:  if (out_ready) state_d = MW_EMPTY;
                default:  state_d = MW_EMPTY;
            endcase
            if (accept) begin
                instr_d = instr_in;
                pc_d    = pc_in;
                state_d = (is_mem_instr(instr_in[MEMCLS_LSB +: 2]) && (WAIT_CYCLES > 0))
                          ? MW_WAIT : MW_FULL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MW_EMPTY;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid    = (state_q == MW_FULL);
    assign busy         = (state_q == MW_WAIT);
    assign instr_output = instr_q;
    assign pc_out       = pc_q;
    assign rt           = instr_q[RT_LSB +: 4];
    assign opcode       = instr_q[OPC_LSB +: OPC_W];
    assign is_mem       = is_mem_instr(instr_q[MEMCLS_LSB +: 2]);

endmodule

// File: tb/tb_memory_wait_stage.sv
// Directed, table-driven bench for memory_wait_stage (WAIT_CYCLES=2) plus an async reset sequence.
module tb_memory_wait_stage;

    localparam logic [31:0] ALU_A = 32'hE0812003;
    localparam logic [31:0] ALU_B = 32'hE2811001;
    localparam logic [31:0] ALU_C = 32'hE1A05006;
    localparam logic [31:0] ALU_D = 32'hE3A07010;
    localparam logic [31:0] ALU_E = 32'hE0434005;
    localparam logic [31:0] LDR   = 32'hE5913000;
    localparam logic [31:0] STR   = 32'hE5823000;

    typedef struct {
        string       name;
        logic        inValid;
        logic [31:0] instr;
        logic [6:0]  pc;
        logic        memAck;
        logic        flushIn;
        logic        outReady;
        logic        expReady;
        logic        expValid;
        logic        expBusy;
        logic [31:0] expInstr;
        logic [6:0]  expPc;
        logic [3:0]  expRt;
        logic [6:0]  expOpc;
        logic        expMem;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [6:0]  pc_in;
    logic        mem_ack;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_output;
    logic [6:0]  pc_out;
    logic [3:0]  rt;
    logic [6:0]  opcode;
    logic        is_mem;
    logic        busy;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    memory_wait_stage #(
        .INSTR_W    (32),
        .PC_W       (7),
        .WAIT_CYCLES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .mem_ack     (mem_ack),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr_output(instr_output),
        .pc_out      (pc_out),
        .rt          (rt),
        .opcode      (opcode),
        .is_mem      (is_mem),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(string n, logic iv, logic [31:0] ins, logic [6:0] pc,
                                   logic ack, logic fl, logic ordy, logic eRdy, logic eVal,
                                   logic eBusy, logic [31:0] eIns, logic [6:0] ePc,
                                   logic [3:0] eRt, logic [6:0] eOpc, logic eMem);
        vec_t v;
        v.name = n;       v.inValid = iv;     v.instr = ins;     v.pc = pc;
        v.memAck = ack;   v.flushIn = fl;     v.outReady = ordy; v.expReady = eRdy;
        v.expValid = eVal; v.expBusy = eBusy; v.expInstr = eIns; v.expPc = ePc;
        v.expRt = eRt;    v.expOpc = eOpc;    v.expMem = eMem;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // in_ready is checked with the cycle's inputs applied; the rest just after the clock edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        in_valid  = v.inValid;
        instr_in  = v.instr;
        pc_in     = v.pc;
        mem_ack   = v.memAck;
        flush     = v.flushIn;
        out_ready = v.outReady;
        #1;
        checkOutput({v.name, " in_ready"}, 32'(in_ready), 32'(v.expReady));
        @(posedge clk);
        #1;
        checkOutput({v.name, " out_valid"}, 32'(out_valid), 32'(v.expValid));
        checkOutput({v.name, " busy"},      32'(busy),      32'(v.expBusy));
        checkOutput({v.name, " instr"},     instr_output,   v.expInstr);
        checkOutput({v.name, " pc"},        32'(pc_out),    32'(v.expPc));
        checkOutput({v.name, " rt"},        32'(rt),        32'(v.expRt));
        checkOutput({v.name, " opcode"},    32'(opcode),    32'(v.expOpc));
        checkOutput({v.name, " is_mem"},    32'(is_mem),    32'(v.expMem));
    endtask

    initial begin
        //                 name                   iv ins    pc     ack fl ord  rdy val bsy expIns expPc  rt     opc    mem
        vecs.push_back(mkVec("alu accept",        1, ALU_A, 7'h05, 0, 0, 1,   1, 1, 0, ALU_A, 7'h05, 4'h2, 7'h04, 0));
        vecs.push_back(mkVec("alu drain",         0, 0,     7'h00, 0, 0, 1,   1, 0, 0, ALU_A, 7'h05, 4'h2, 7'h04, 0));
        vecs.push_back(mkVec("ldr accept",        1, LDR,   7'h10, 0, 0, 1,   1, 0, 1, LDR,   7'h10, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("ldr wait1",         1, ALU_B, 7'h15, 0, 0, 1,   0, 0, 1, LDR,   7'h10, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("ldr wait2",         0, 0,     7'h00, 0, 0, 1,   0, 1, 0, LDR,   7'h10, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("str accept",        1, STR,   7'h11, 1, 0, 1,   1, 0, 1, STR,   7'h11, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("str ack",           0, 0,     7'h00, 1, 0, 1,   0, 1, 0, STR,   7'h11, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("full stall",        1, ALU_A, 7'h20, 0, 0, 0,   0, 1, 0, STR,   7'h11, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("ldr b2b",           1, LDR,   7'h12, 0, 0, 1,   1, 0, 1, LDR,   7'h12, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("ldr2 wait1",        0, 0,     7'h00, 0, 0, 1,   0, 0, 1, LDR,   7'h12, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("ldr2 wait2",        0, 0,     7'h00, 0, 0, 1,   0, 1, 0, LDR,   7'h12, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("stream b",          1, ALU_B, 7'h21, 0, 0, 1,   1, 1, 0, ALU_B, 7'h21, 4'h1, 7'h14, 0));
        vecs.push_back(mkVec("stream stall",      1, ALU_C, 7'h22, 0, 0, 0,   0, 1, 0, ALU_B, 7'h21, 4'h1, 7'h14, 0));
        vecs.push_back(mkVec("stream c",          1, ALU_C, 7'h22, 0, 0, 1,   1, 1, 0, ALU_C, 7'h22, 4'h5, 7'h0D, 0));
        vecs.push_back(mkVec("stream d",          1, ALU_D, 7'h23, 0, 0, 1,   1, 1, 0, ALU_D, 7'h23, 4'h7, 7'h1D, 0));
        vecs.push_back(mkVec("stream e",          1, ALU_E, 7'h24, 0, 0, 1,   1, 1, 0, ALU_E, 7'h24, 4'h4, 7'h02, 0));
        vecs.push_back(mkVec("e hold ack",        0, 0,     7'h00, 1, 0, 0,   0, 1, 0, ALU_E, 7'h24, 4'h4, 7'h02, 0));
        vecs.push_back(mkVec("e drain",           0, 0,     7'h00, 0, 0, 1,   1, 0, 0, ALU_E, 7'h24, 4'h4, 7'h02, 0));
        vecs.push_back(mkVec("ldr3 accept",       1, LDR,   7'h30, 0, 0, 0,   1, 0, 1, LDR,   7'h30, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("flush in wait",     1, ALU_A, 7'h31, 1, 1, 1,   0, 0, 0, LDR,   7'h30, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("flush in empty",    1, ALU_A, 7'h32, 0, 1, 1,   0, 0, 0, LDR,   7'h30, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("empty ack",         0, 0,     7'h00, 1, 0, 1,   1, 0, 0, LDR,   7'h30, 4'h3, 7'h2C, 1));
        vecs.push_back(mkVec("alu after flush",   1, ALU_A, 7'h33, 0, 0, 1,   1, 1, 0, ALU_A, 7'h33, 4'h2, 7'h04, 0));
        vecs.push_back(mkVec("flush in full",     1, ALU_B, 7'h34, 0, 1, 1,   0, 0, 0, ALU_A, 7'h33, 4'h2, 7'h04, 0));

        rst = 1'b1; in_valid = 1'b0; instr_in = '0; pc_in = '0;
        mem_ack = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        checkOutput("reset in_ready",  32'(in_ready),  32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset busy",      32'(busy),      32'd0);
        checkOutput("reset instr",     instr_output,   32'd0);
        checkOutput("reset pc",        32'(pc_out),    32'd0);
        #11;
        rst = 1'b0;
        #1;
        checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset asserted mid-WAIT must clear everything without waiting for a clock edge.
        @(negedge clk);
        in_valid = 1'b1; instr_in = LDR; pc_in = 7'h40; out_ready = 1'b1;
        mem_ack = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre-reset busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst busy",     32'(busy),      32'd0);
        checkOutput("async rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("async rst instr",    instr_output,   32'd0);
        checkOutput("async rst pc",       32'(pc_out),    32'd0);
        checkOutput("async rst rt",       32'(rt),        32'd0);
        checkOutput("async rst opcode",   32'(opcode),    32'd0);
        checkOutput("async rst is_mem",   32'(is_mem),    32'd0);
        checkOutput("async rst in_ready", 32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        checkOutput("held rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst release in_ready", 32'(in_ready), 32'd1);
        applyStimulus(mkVec("alu after reset", 1, ALU_A, 7'h41, 0, 0, 1, 1, 1, 0, ALU_A, 7'h41, 4'h2, 7'h04, 0));
        applyStimulus(mkVec("drain after reset", 0, 0, 7'h00, 0, 0, 1, 1, 0, 0, ALU_A, 7'h41, 4'h2, 7'h04, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
